// File: rtl/mc_residual.sv
// mc_residual: re-reads the winning 16x16 reference block and current
// macroblock, emits one row of signed residuals (cur - ref) per cycle.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, mv_x, mv_y,    launch with MV and SAD reported by motion estimation
//   min_sad
//   busy                  operation in progress (through the done cycle)
//   ref_en/row/col        search-window RAM read (16 pixels from ref_col)
//   ref_pixel_in          reference row, valid the cycle after ref_en
//   cur_en/cur_addr       current-MB RAM read, issued with ref_en
//   cur_pixel_in          current row, same latency
//   res_out/row/valid/    residual row stream to the transform stage,
//   res_ready/res_last    valid/ready handshake, last marks row 15
//   done                  one-cycle completion pulse
//   sad_out               SAD of transferred residuals
//   sad_mismatch          with done: sad_out differs from min_sad
//   mv_err                an MV was clamped at start
module mc_residual #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [5:0]                 mv_x,
  input  logic [5:0]                 mv_y,
  input  logic [15:0]                min_sad,
  output logic                       busy,
  output logic                       ref_en,
  output logic [5:0]                 ref_row,
  output logic [5:0]                 ref_col,
  input  logic [MACRO_DIM-1:0][7:0]  ref_pixel_in,
  output logic                       cur_en,
  output logic [3:0]                 cur_addr,
  input  logic [MACRO_DIM-1:0][7:0]  cur_pixel_in,
  output logic [MACRO_DIM-1:0][8:0]  res_out,
  output logic [3:0]                 res_row,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_last,
  output logic                       done,
  output logic [15:0]                sad_out,
  output logic                       sad_mismatch,
  output logic                       mv_err
);

  localparam logic [5:0] MV_MAX = 6'(SEARCH_DIM - MACRO_DIM);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [5:0]  mv_x_l;
  logic [5:0]  mv_y_l;
  logic [15:0] min_sad_l;
  logic [3:0]  row_cnt;
  logic        rd_vld;
  logic [3:0]  rd_row;

  logic [MACRO_DIM-1:0][8:0] fifo_data [2];
  logic [3:0]                fifo_row  [2];
  logic                      wr_ptr;
  logic                      rd_ptr;
  logic [1:0]                occ;

  logic                      accept;
  logic                      push;
  logic                      pop;
  logic                      issue;
  logic [1:0]                credit;
  logic [MACRO_DIM-1:0][8:0] diff;
  logic [11:0]               row_sum;

  assign accept = start && (state == IDLE);
  assign push   = rd_vld;
  assign pop    = res_valid && res_ready;

  // Rows already committed to the FIFO once this cycle's pop leaves and
  // the returning read lands; a new read is safe only if one slot remains.
  assign credit = occ - {1'b0, pop} + {1'b0, rd_vld};
  assign issue  = (state == FETCH) && (credit < 2'd2);

  assign ref_en   = issue;
  assign cur_en   = issue;
  assign ref_row  = mv_y_l + {2'b00, row_cnt};
  assign ref_col  = mv_x_l;
  assign cur_addr = row_cnt;

  assign res_valid    = (occ != 2'd0);
  assign res_out      = fifo_data[rd_ptr];
  assign res_row      = fifo_row[rd_ptr];
  assign res_last     = res_valid && (res_row == 4'd15);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign sad_mismatch = done && (sad_out != min_sad_l);

  always_comb begin
    diff = '0;
    for (int i = 0; i < MACRO_DIM; i++) begin
      diff[i] = {1'b0, cur_pixel_in[i]} - {1'b0, ref_pixel_in[i]};
    end
  end

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < MACRO_DIM; i++) begin
      if (res_out[i][8]) begin
        row_sum = row_sum + 12'(9'(-res_out[i]));
      end else begin
        row_sum = row_sum + 12'(res_out[i]);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = FETCH;
      end
      FETCH: begin
        if (issue && (row_cnt == 4'd15)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (pop && (res_row == 4'd15)) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_x_l    <= '0;
      mv_y_l    <= '0;
      min_sad_l <= '0;
      mv_err    <= 1'b0;
    end else if (accept) begin
      mv_x_l    <= (mv_x > MV_MAX) ? MV_MAX : mv_x;
      mv_y_l    <= (mv_y > MV_MAX) ? MV_MAX : mv_y;
      min_sad_l <= min_sad;
      mv_err    <= (mv_x > MV_MAX) || (mv_y > MV_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      rd_vld  <= 1'b0;
      rd_row  <= '0;
    end else begin
      rd_vld <= issue;
      rd_row <= row_cnt;
      if (accept) begin
        row_cnt <= '0;
      end else if (issue) begin
        row_cnt <= row_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_row[0]  <= '0;
      fifo_row[1]  <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      occ          <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= diff;
        fifo_row[wr_ptr]  <= rd_row;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad_out <= '0;
    end else if (accept) begin
      sad_out <= '0;
    end else if (pop) begin
      sad_out <= sad_out + {4'd0, row_sum};
    end
  end

endmodule

// File: tb/tb_mc_residual.sv
// tb_mc_residual: directed + randomized bench for mc_residual with RAM
// models and an array-based reference for residual rows and SAD.
module tb_mc_residual;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [5:0]        mv_x;
  logic [5:0]        mv_y;
  logic [15:0]       min_sad;
  logic              busy;
  logic              ref_en;
  logic [5:0]        ref_row;
  logic [5:0]        ref_col;
  logic [15:0][7:0]  ref_pixel_in;
  logic              cur_en;
  logic [3:0]        cur_addr;
  logic [15:0][7:0]  cur_pixel_in;
  logic [15:0][8:0]  res_out;
  logic [3:0]        res_row;
  logic              res_valid;
  logic              res_ready;
  logic              res_last;
  logic              done;
  logic [15:0]       sad_out;
  logic              sad_mismatch;
  logic              mv_err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] srch [0:47][0:47];
  logic [7:0] curm [0:15][0:15];

  mc_residual dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mv_x         (mv_x),
    .mv_y         (mv_y),
    .min_sad      (min_sad),
    .busy         (busy),
    .ref_en       (ref_en),
    .ref_row      (ref_row),
    .ref_col      (ref_col),
    .ref_pixel_in (ref_pixel_in),
    .cur_en       (cur_en),
    .cur_addr     (cur_addr),
    .cur_pixel_in (cur_pixel_in),
    .res_out      (res_out),
    .res_row      (res_row),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_last     (res_last),
    .done         (done),
    .sad_out      (sad_out),
    .sad_mismatch (sad_mismatch),
    .mv_err       (mv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ref_en) begin
      for (int i = 0; i < 16; i++) begin
        ref_pixel_in[i] <= srch[int'(ref_row)][int'(ref_col) + i];
      end
    end
    if (cur_en) begin
      for (int i = 0; i < 16; i++) begin
        cur_pixel_in[i] <= curm[int'(cur_addr)][i];
      end
    end
  end

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pix_diff(int cx, int cy, int r, int i);
    return int'(curm[r][i]) - int'(srch[cy + r][cx + i]);
  endfunction

  function automatic logic [143:0] exp_row(int cx, int cy, int r);
    logic [143:0] e;
    int d;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      d = pix_diff(cx, cy, r, i);
      e[i*9 +: 9] = d[8:0];
    end
    return e;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk(tag, {busy, ref_en, cur_en, res_valid, res_last, done,
              sad_mismatch, mv_err, ref_row, ref_col, cur_addr,
              res_row, sad_out}, '0);
    chk({tag, "_res"}, res_out, '0);
  endtask

  // mode 0: ready held 1; 1: ready 1,0,0,1 repeating; 2: random.
  // ms_auto: min_sad set to the reference SAD. abort_at >= 0: pulse a
  // second start mid-fetch, then reset once that row is issued.
  task automatic run_op(input int mx, input int my, input logic [15:0] ms,
                        input bit ms_auto, input int mode,
                        input int abort_at);
    int cx, cy, issued, xfer, first_v, last_v, last_en, d;
    logic [15:0] esad, msv;
    bit fin;
    cx = (mx > 32) ? 32 : mx;
    cy = (my > 32) ? 32 : my;
    esad = 0;
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 16; i++) begin
        d = pix_diff(cx, cy, r, i);
        esad += 16'((d < 0) ? -d : d);
      end
    end
    msv = ms_auto ? esad : ms;
    @(negedge clk);
    mv_x = 6'(mx);
    mv_y = 6'(my);
    min_sad = msv;
    start = 1'b1;
    @(posedge clk);
    issued = 0;
    xfer = 0;
    first_v = -1;
    last_v = -1;
    last_en = -1;
    fin = 0;
    for (int j = 1; j <= 400 && !fin; j++) begin
      @(negedge clk);
      start = 1'b0;
      case (mode)
        0: res_ready = 1'b1;
        1: res_ready = (j % 4 == 1) || (j % 4 == 0);
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
      if (j == 4 && abort_at >= 0) begin
        start = 1'b1;
        mv_x = 6'd3;
        mv_y = 6'd7;
      end
      #1;
      if (j == 1) begin
        chk("busy_after_start", busy, 1);
        chk("mv_err", mv_err, (mx > 32 || my > 32));
        chk("sad_cleared", sad_out, 0);
      end
      if (ref_en) begin
        chk("cur_en", cur_en, 1);
        chk("ref_row", ref_row, cy + issued);
        chk("ref_col", ref_col, cx);
        chk("cur_addr", cur_addr, issued);
        issued++;
        last_en = j;
      end
      if (res_valid) begin
        if (first_v < 0) first_v = j;
        last_v = j;
      end
      if (res_valid && res_ready) begin
        chk("res_row", res_row, xfer);
        chk("res_out", res_out, exp_row(cx, cy, xfer));
        chk("res_last", res_last, (xfer == 15));
        xfer++;
      end
      chk("buffered_le_2", (issued - xfer <= 2), 1);
      if (abort_at >= 0 && issued == abort_at + 1) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort_outputs");
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("no_done_in_reset", done, 0);
        end
        rst_n = 1'b1;
        fin = 1;
      end else if (done) begin
        chk("done_rows", xfer, 16);
        chk("done_issued", issued, 16);
        chk("sad_out", sad_out, esad);
        chk("sad_mismatch", sad_mismatch, (esad != msv));
        if (mode == 0) begin
          chk("lat_done", j, 19);
          chk("lat_first_valid", first_v, 3);
          chk("lat_last_valid", last_v, 18);
          chk("lat_last_ref_en", last_en, 16);
        end
        fin = 1;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    @(negedge clk);
    if (abort_at < 0) begin
      chk("idle_after_done", {busy, done}, 0);
      chk("sad_held", sad_out, esad);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mv_x = '0;
    mv_y = '0;
    min_sad = '0;
    res_ready = 1'b0;
    ref_pixel_in = '0;
    cur_pixel_in = '0;
    #1;
    chk_all_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // identity: cur equals the window corner, mv (0,0)
    for (int y = 0; y < 48; y++)
      for (int x = 0; x < 48; x++) srch[y][x] = 8'($urandom);
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 16; i++) curm[r][i] = srch[r][i];
    run_op(0, 0, 16'd0, 0, 0, -1);

    // offset MV on a ramp window
    for (int y = 0; y < 48; y++)
      for (int x = 0; x < 48; x++) srch[y][x] = 8'(x + y);
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 16; i++) curm[r][i] = 8'h20;
    run_op(5, 9, 16'd0, 1, 0, -1);

    // same stimulus under backpressure
    run_op(5, 9, 16'd0, 1, 1, -1);

    // extremes: +255 then -255
    for (int y = 0; y < 48; y++)
      for (int x = 0; x < 48; x++) srch[y][x] = 8'h00;
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 16; i++) curm[r][i] = 8'hFF;
    run_op(3, 4, 16'd0, 0, 0, -1);
    for (int y = 0; y < 48; y++)
      for (int x = 0; x < 48; x++) srch[y][x] = 8'hFF;
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 16; i++) curm[r][i] = 8'h00;
    run_op(1, 2, 16'd65280, 0, 0, -1);

    // clamp on random data
    for (int y = 0; y < 48; y++)
      for (int x = 0; x < 48; x++) srch[y][x] = 8'($urandom);
    for (int r = 0; r < 16; r++)
      for (int i = 0; i < 16; i++) curm[r][i] = 8'($urandom);
    run_op(40, 33, 16'd0, 1, 0, -1);

    // ignored second start, then reset mid-fetch, then a clean run
    run_op(10, 20, 16'd0, 1, 0, 7);
    run_op(10, 20, 16'd0, 1, 0, -1);

    // randomized MVs, data and handshake
    for (int t = 0; t < 8; t++) begin
      for (int y = 0; y < 48; y++)
        for (int x = 0; x < 48; x++) srch[y][x] = 8'($urandom);
      for (int r = 0; r < 16; r++)
        for (int i = 0; i < 16; i++) curm[r][i] = 8'($urandom);
      run_op(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
             16'($urandom), 1'($urandom_range(0, 1)), 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_residual.md
Name: mc_residual

Overview:
- Motion-compensation residual stage. Sits directly downstream of the motion-estimation block `me`.
- Takes the winning motion vector (mv_x, mv_y) and min_sad, then re-reads the matched 16x16 reference block from the search-window RAM and the current macroblock from the current-picture RAM.
- Emits one row of 16 signed residuals (cur − ref) per cycle to the transform stage, with valid/ready backpressure.
- Accumulates the SAD of the emitted residuals and compares it against min_sad as a consistency check.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels.
- SEARCH_DIM, 48, search-window edge in pixels; legal MV range is 0..SEARCH_DIM−MACRO_DIM.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches mv_x, mv_y, min_sad. Accepted only in IDLE.
- mv_x  in  6  horizontal MV from `me`.
- mv_y  in  6  vertical MV from `me`.
- min_sad  in  16  SAD reported by `me`.
- busy  out  1  high from the cycle after an accepted start until done.
- ref_en  out  1  search RAM read enable.
- ref_row  out  6  search-window row = mv_y_l + r.
- ref_col  out  6  first column = mv_x_l; RAM returns 16 consecutive pixels.
- ref_pixel_in  in  8 x MACRO_DIM  reference pixels. Synchronous RAM: valid the cycle after ref_en.
- cur_en  out  1  current-MB RAM read enable; always equal to ref_en.
- cur_addr  out  4  current-MB row r.
- cur_pixel_in  in  8 x MACRO_DIM  current pixels, same 1-cycle latency.
- res_out  out  9 (signed) x MACRO_DIM  residual row.
- res_row  out  4  row index of res_out.
- res_valid  out  1  res_out valid.
- res_ready  in  1  downstream accept; transfer occurs when res_valid && res_ready.
- res_last  out  1  high with row 15.
- done  out  1  one-cycle pulse after row 15 transfers.
- sad_out  out  16  accumulated Σ|residual|; held until the next start.
- sad_mismatch  out  1  set with done when sad_out != min_sad_l.
- mv_err  out  1  set at start if either MV exceeds SEARCH_DIM−MACRO_DIM.

Behaviour:
- Reset: every output is 0. State = IDLE. FIFO empty. Counters 0. Reset mid-operation aborts immediately, no done pulse.
- States:
  - IDLE → FETCH on start.
  - FETCH issues reads for rows 0..15, then → DRAIN.
  - DRAIN waits for the FIFO to empty and row 15 to transfer, then → DONE.
  - DONE lasts one cycle: done=1, sad_mismatch valid. Then → IDLE.
- start while busy is ignored; the latched MV is not disturbed.
- MV clamp: mv_x or mv_y > SEARCH_DIM−MACRO_DIM (32) saturates to 32 and sets mv_err. mv_err is cleared at the next accepted start.
- Read pipeline:
  - A read for row r is issued (ref_en=cur_en=1) only when FIFO occupancy + in-flight reads < 2.
  - r increments per issued read.
  - Residual = {1'b0,cur} − {1'b0,ref}, range −255..255. It is registered into a 2-entry output FIFO on the cycle the data returns.
- Output:
  - res_out, res_row and res_last come from the FIFO head.
  - res_out stays stable while res_valid && !res_ready.
  - Rows leave strictly in order 0..15.
- Latency, with res_ready held 1 and start sampled on edge C:
  - ref_en on C+1..C+16.
  - res_valid on C+3..C+18.
  - done on C+19.
  - Throughput: 1 row/cycle.
- Backpressure: holding res_ready=0 stalls issue after at most 2 buffered rows. No row is lost or duplicated.
- SAD:
  - sad_out is cleared at start.
  - It adds Σ|res_out[i]| on each transfer. Width 16; the maximum 65280 does not overflow.
- Simultaneous events: FIFO push and pop in the same cycle leave occupancy unchanged.

Test Plan:
- Identity: cur = ref window at mv=(0,0), min_sad=0, res_ready=1.
  - Expect 16 rows of all-zero residuals, res_valid on C+3..C+18, done at C+19, sad_out=0, sad_mismatch=0.
- Offset MV: mv_x=5, mv_y=9, search pixel(x,y)=x+y, cur all 0x20, min_sad matched.
  - Expect ref_row 9..24, ref_col=5.
  - Row r residual[i] = 32 − (i+5+r+9). sad_out equals the computed value; sad_mismatch=0.
- Backpressure: same stimulus, res_ready toggling 1,0,0,1.
  - Expect ≤2 rows buffered, ref_en gated, identical row sequence, done only after row 15 transfers.
- Extremes: cur=0xFF, ref=0x00, min_sad=0.
  - Expect residuals +255, sad_out=65280, sad_mismatch=1.
  - Swap the values: expect residuals −255 (9'h101).
- Clamp: mv_x=40, mv_y=33.
  - Expect mv_err=1, ref_col=32, ref_row starting at 32.
- Control: start pulsed mid-FETCH, then rst_n low at row 7.
  - Expect the second start ignored.
  - After reset: all outputs 0, no done pulse, next start runs normally.
